adc_osr_reader: RTL

Receiving end of the SAR controller's result interface. It captures each converted word on the conversion-finished strobe, accumulates a configurable number of conversions (oversampling with decimation), and emits left-justified 16-bit words through a 4-entry FIFO with a valid/ready handshake. It sits between the SAR control core and the wishbone/readout logic in the same clock domain, so the core's data-valid strobe is never used as a clock.

---
 rtl/adc_osr_reader_if.sv | 21 ++
 rtl/adc_osr_reader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/adc_osr_reader_if.sv
// Readout handshake bundle between the oversampling reader and its consumer.
// The reader drives the head word and its valid flag, and the consumer answers with ready.
interface adc_osr_reader_if #(
   parameter int OUT_BITS = 16
);
   logic [OUT_BITS-1:0] data_out;
   logic                data_valid_out;
   logic                data_ready_in;

   modport master (
      output data_out,
      output data_valid_out,
      input  data_ready_in
   );

   modport slave (
      input  data_out,
      input  data_valid_out,
      output data_ready_in
   );
endinterface

// File: rtl/adc_osr_reader.sv
// Receives SAR results on the conversion-finished strobe and accumulates N of them per frame.
// Each completed frame is decimated to a left-justified word and queued in a small show-ahead FIFO.
// Everything runs on the SAR core's clock; the strobe is treated as an ordinary enable.
module adc_osr_reader #(
   parameter int MATRIX_BITS = 12,
   parameter int OUT_BITS    = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [MATRIX_BITS-1:0] result_in,
   input  logic                   conv_finished_strobe_in,
   input  logic [2:0]             osr_control_in,
   input  logic                   clear_in,
   adc_osr_reader_if.master       readout,
   output logic [2:0]             fifo_level_out,
   output logic                   overflow_out
);

   localparam int ACC_BITS = MATRIX_BITS + 8;
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam logic [2:0] FULL_LEVEL = 3'(FIFO_DEPTH);

   logic [ACC_BITS-1:0] acc_q, acc_d;
   logic [8:0]          cnt_q, cnt_d;
   logic [8:0]          osrN_q, osrN_d;
   logic [2:0]          osrK_q, osrK_d;

   logic [OUT_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_BITS-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_BITS-1:0] rdPtr_q, rdPtr_d;
   logic [2:0]          level_q, level_d;
   logic                overflow_q, overflow_d;

   logic                flush;
   logic                strobeOk;
   logic [8:0]          decN;
   logic [2:0]          decK;
   logic [8:0]          nEff;
   logic [2:0]          kEff;
   logic [ACC_BITS-1:0] accSum;
   logic [8:0]          cntInc;
   logic                frameDone;
   logic [OUT_BITS-1:0] frameWord;
   logic                fifoEmpty;
   logic                fifoFull;
   logic                pop;
   logic                push;
   logic                dropped;

   assign flush    = !rst_n || clear_in;
   assign strobeOk = conv_finished_strobe_in && !flush;

   // Translate the oversampling select into conversions-per-frame and the decimation shift.
   always_comb begin
      decN = 9'd1;
      decK = 3'd0;
      case (osr_control_in)
         3'd1: begin decN = 9'd4;   decK = 3'd1; end
         3'd2: begin decN = 9'd16;  decK = 3'd2; end
         3'd3: begin decN = 9'd64;  decK = 3'd3; end
         3'd4: begin decN = 9'd256; decK = 3'd4; end
         default: begin decN = 9'd1; decK = 3'd0; end
      endcase
   end

   // Frame accumulation: the first strobe of a frame uses the live select, later strobes the latched one.
   always_comb begin
      nEff      = (cnt_q == 9'd0) ? decN : osrN_q;
      kEff      = (cnt_q == 9'd0) ? decK : osrK_q;
      accSum    = acc_q + ACC_BITS'(result_in);
      cntInc    = cnt_q + 9'd1;
      frameDone = strobeOk && (cntInc == nEff);
      frameWord = OUT_BITS'((accSum >> kEff) << (3'd4 - kEff));
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      osrN_d    = osrN_q;
      osrK_d    = osrK_q;
      if (strobeOk) begin
         osrN_d = nEff;
         osrK_d = kEff;
         if (cntInc == nEff) begin
            acc_d = '0;
            cnt_d = 9'd0;
         end else begin
            acc_d = accSum;
            cnt_d = cntInc;
         end
      end
   end

   // FIFO bookkeeping: a pop frees a slot in the same cycle, so a push into a full FIFO survives only alongside a pop.
   always_comb begin
      fifoEmpty  = (level_q == 3'd0);
      fifoFull   = (level_q == FULL_LEVEL);
      pop        = !fifoEmpty && readout.data_ready_in && !flush;
      push       = frameDone && (!fifoFull || pop);
      dropped    = frameDone && fifoFull && !pop;
      wrPtr_d    = push ? wrPtr_q + PTR_BITS'(1) : wrPtr_q;
      rdPtr_d    = pop ? rdPtr_q + PTR_BITS'(1) : rdPtr_q;
      overflow_d = overflow_q || dropped;
      case ({push, pop})
         2'b10:   level_d = level_q + 3'd1;
         2'b01:   level_d = level_q - 3'd1;
         default: level_d = level_q;
      endcase
   end

   // State registers; clear behaves exactly like reset and discards any strobe in the same cycle.
   always_ff @(posedge clk) begin
      if (flush) begin
         acc_q      <= '0;
         cnt_q      <= 9'd0;
         osrN_q     <= 9'd1;
         osrK_q     <= 3'd0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= 3'd0;
         overflow_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         osrN_q     <= osrN_d;
         osrK_q     <= osrK_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage needs no reset because the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= frameWord;
      end
   end

   assign readout.data_valid_out = !fifoEmpty;
   assign readout.data_out       = fifoEmpty ? '0 : mem_q[rdPtr_q];
   assign fifo_level_out         = level_q;
   assign overflow_out           = overflow_q;

endmodule
